cache_ctrl_gen2: RTL and testbench

CACHE_CTRL_GEN2 -- requirements
Module: cache_ctrl_gen2

---
 rtl/cache_ctrl_gen2.sv | 183 ++++++++++++++++++
 tb/tb_cache_ctrl_gen2.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_gen2.sv
// cache_ctrl_gen2: cache controller sequencing I/D hits, dirty write-back,
// line fills and memory timeouts, with starvation-bounded I/D arbitration.
module cache_ctrl_gen2 #(
    parameter int ADDR_W       = 16,
    parameter int WORD_W       = 16,
    parameter int LINE_WORDS   = 4,
    parameter int TAG_W        = 8,
    parameter int MEM_TIMEOUT  = 255,
    parameter int STARVE_MAX   = 3,
    localparam int OFF_W       = $clog2(LINE_WORDS),
    localparam int LINE_W      = WORD_W * LINE_WORDS,
    localparam int IDX_W       = ADDR_W - OFF_W - TAG_W,
    localparam int MA_W        = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_hit,
    output logic              i_we,
    output logic [LINE_W-1:0] i_wr_line,
    output logic              i_rdy,
    input  logic              d_re_req,
    input  logic              d_we_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic              d_hit,
    input  logic              d_dirty,
    input  logic [TAG_W-1:0]  d_tag,
    input  logic [LINE_W-1:0] d_rd_line,
    output logic              d_re,
    output logic              d_we,
    output logic              d_dirty_wr,
    output logic [LINE_W-1:0] d_wr_line,
    output logic              d_rdy,
    output logic [MA_W-1:0]   m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [LINE_W-1:0] m_wr_line,
    input  logic [LINE_W-1:0] m_rd_line,
    input  logic              m_rdy,
    output logic              m_err,
    output logic              err_sticky,
    output logic              idle
);

    localparam int TO_B = $clog2(MEM_TIMEOUT + 1);
    localparam int TO_W = (TO_B > 8) ? TO_B : 8;
    localparam int SV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_D_RD, S_D_WR, S_WB, S_FILL_D, S_FILL_I, S_I_RD, S_ERR
    } state_t;

    state_t          state, state_d;
    logic            we_q, we_d;
    logic [SV_W-1:0] starve, starve_d;
    logic [TO_W-1:0] tcnt, tcnt_d;
    logic            err_d;
    logic            d_req, i_pick, mem_st, to_hit;
    logic            unused;

    assign unused = ^i_addr[OFF_W-1:0];
    assign d_req  = d_re_req | d_we_req;
    assign i_pick = i_req & (~d_req | (starve == SV_W'(STARVE_MAX)));
    assign mem_st = (state == S_WB) | (state == S_FILL_D) | (state == S_FILL_I);
    assign to_hit = (tcnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            starve     <= '0;
            tcnt       <= '0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_d;
            we_q       <= we_d;
            starve     <= starve_d;
            tcnt       <= tcnt_d;
            err_sticky <= err_d;
        end
    end

    always_comb begin
        state_d    = state;
        we_d       = we_q;
        starve_d   = starve;
        tcnt_d     = tcnt;
        err_d      = err_sticky;
        i_we       = 1'b0;
        i_rdy      = 1'b0;
        i_wr_line  = m_rd_line;
        d_re       = 1'b0;
        d_we       = 1'b0;
        d_dirty_wr = 1'b0;
        d_wr_line  = d_rd_line;
        d_rdy      = 1'b0;
        m_addr     = '0;
        m_re       = 1'b0;
        m_we       = 1'b0;
        m_wr_line  = d_rd_line;
        m_err      = 1'b0;
        idle       = 1'b0;
        // Reset forces every strobe low combinationally, even IDLE's.
        if (rst_n) begin
            unique case (state)
                S_IDLE: begin
                    idle = 1'b1;
                    d_re = 1'b1;
                    tcnt_d = '0;
                    if (i_pick) begin
                        starve_d = '0;
                        state_d  = i_hit ? S_I_RD : S_FILL_I;
                    end else if (d_req) begin
                        we_d     = d_we_req;
                        starve_d = i_req ? starve + SV_W'(1) : '0;
                        if (d_hit)
                            state_d = d_we_req ? S_D_WR : S_D_RD;
                        else
                            state_d = d_dirty ? S_WB : S_FILL_D;
                    end else begin
                        starve_d = '0;
                    end
                end
                S_WB: begin
                    m_we   = 1'b1;
                    d_re   = 1'b1;
                    m_addr = {d_tag, d_addr[OFF_W+IDX_W-1:OFF_W]};
                    if (m_rdy) begin
                        state_d = S_FILL_D;
                        tcnt_d  = '0;
                    end
                end
                S_FILL_D: begin
                    m_re      = 1'b1;
                    m_addr    = d_addr[ADDR_W-1:OFF_W];
                    d_wr_line = m_rd_line;
                    if (m_rdy) begin
                        d_we    = 1'b1;
                        state_d = we_q ? S_D_WR : S_D_RD;
                    end
                end
                S_FILL_I: begin
                    m_re   = 1'b1;
                    m_addr = i_addr[ADDR_W-1:OFF_W];
                    if (m_rdy) begin
                        i_we    = 1'b1;
                        state_d = S_I_RD;
                    end
                end
                S_D_WR: begin
                    d_we       = 1'b1;
                    d_dirty_wr = 1'b1;
                    d_rdy      = 1'b1;
                    d_wr_line[d_addr[OFF_W-1:0]*WORD_W +: WORD_W] = d_wdata;
                    state_d    = S_IDLE;
                end
                S_D_RD: begin
                    d_re    = 1'b1;
                    d_rdy   = 1'b1;
                    state_d = S_IDLE;
                end
                S_I_RD: begin
                    i_rdy   = 1'b1;
                    state_d = S_IDLE;
                end
                S_ERR: begin
                    m_err   = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
            if (mem_st && !m_rdy) begin
                tcnt_d = tcnt + TO_W'(1);
                if (to_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_gen2.sv
// tb_cache_ctrl_gen2: directed and randomized transactions checked against
// a transaction-level model of the controller's observable behaviour.
module tb_cache_ctrl_gen2;

    localparam int AW  = 16;
    localparam int WW  = 16;
    localparam int LWD = 4;
    localparam int TW  = 8;
    localparam int MT  = 255;
    localparam int OW  = 2;
    localparam int LW  = WW * LWD;
    localparam int IW  = AW - OW - TW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_req, i_hit, i_we, i_rdy;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_wr_line;
    logic          d_re_req, d_we_req, d_hit, d_dirty;
    logic [AW-1:0] d_addr;
    logic [WW-1:0] d_wdata;
    logic [TW-1:0] d_tag;
    logic [LW-1:0] d_rd_line, d_wr_line, m_wr_line, m_rd_line;
    logic          d_re, d_we, d_dirty_wr, d_rdy;
    logic [AW-OW-1:0] m_addr;
    logic          m_re, m_we, m_rdy, m_err, err_sticky, idle;

    cache_ctrl_gen2 dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_hit(i_hit),
        .i_we(i_we), .i_wr_line(i_wr_line), .i_rdy(i_rdy),
        .d_re_req(d_re_req), .d_we_req(d_we_req), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_hit(d_hit), .d_dirty(d_dirty),
        .d_tag(d_tag), .d_rd_line(d_rd_line),
        .d_re(d_re), .d_we(d_we), .d_dirty_wr(d_dirty_wr),
        .d_wr_line(d_wr_line), .d_rdy(d_rdy),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
        .m_wr_line(m_wr_line), .m_rd_line(m_rd_line), .m_rdy(m_rdy),
        .m_err(m_err), .err_sticky(err_sticky), .idle(idle)
    );

    // Wide-line instance: 8 words of 32 bits.
    logic           w_we_req, w_hit;
    logic [15:0]    w_addr;
    logic [31:0]    w_wdata;
    logic [255:0]   w_rd_line;
    logic           w_i_we, w_i_rdy, w_d_re, w_d_we, w_d_dirty_wr, w_d_rdy;
    logic [255:0]   w_i_wr_line, w_d_wr_line, w_m_wr_line;
    logic [12:0]    w_m_addr;
    logic           w_m_re, w_m_we, w_m_err, w_err_sticky, w_idle;

    cache_ctrl_gen2 #(.LINE_WORDS(8), .WORD_W(32)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .i_req(1'b0), .i_addr(16'h0), .i_hit(1'b0),
        .i_we(w_i_we), .i_wr_line(w_i_wr_line), .i_rdy(w_i_rdy),
        .d_re_req(1'b0), .d_we_req(w_we_req), .d_addr(w_addr),
        .d_wdata(w_wdata), .d_hit(w_hit), .d_dirty(1'b0),
        .d_tag(8'h0), .d_rd_line(w_rd_line),
        .d_re(w_d_re), .d_we(w_d_we), .d_dirty_wr(w_d_dirty_wr),
        .d_wr_line(w_d_wr_line), .d_rdy(w_d_rdy),
        .m_addr(w_m_addr), .m_re(w_m_re), .m_we(w_m_we),
        .m_wr_line(w_m_wr_line), .m_rd_line(256'h0), .m_rdy(1'b0),
        .m_err(w_m_err), .err_sticky(w_err_sticky), .idle(w_idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom};
    endfunction

    // One memory phase: kind 0 = write-back, 1 = D fill, 2 = I fill.
    task automatic mem_phase(input int kind, input int exp_addr,
                             input int dly, input logic [LW-1:0] line);
        for (int k = 0; k <= dly; k++) begin
            m_rdy = (k == dly);
            @(negedge clk);
            check("ph_mwe", m_we, kind == 0);
            check("ph_mre", m_re, kind != 0);
            check("ph_addr", m_addr, exp_addr);
            check("ph_rdy", {d_rdy, i_rdy}, 0);
            if (kind == 0) check("wb_line", m_wr_line, line);
            if (kind == 1) check("fd_line", d_wr_line, line);
            if (kind == 2) check("fi_line", i_wr_line, line);
            check("ph_dwe", d_we, (kind == 1) && (k == dly));
            check("ph_iwe", i_we, (kind == 2) && (k == dly));
            next_cycle();
        end
        m_rdy = 1'b0;
    endtask

    task automatic d_txn(input bit we, input bit hit, input bit dirty,
                         input logic [AW-1:0] a, input logic [TW-1:0] t,
                         input int dw, input int df);
        logic [WW-1:0] wd;
        logic [LW-1:0] rl, ml, mask, exp_l;
        int sh;
        wd = WW'($urandom);
        rl = rnd_line();
        ml = rnd_line();
        d_addr = a; d_tag = t; d_wdata = wd;
        d_rd_line = rl; m_rd_line = ml;
        d_hit = hit; d_dirty = dirty; i_req = 1'b0; m_rdy = 1'b0;
        d_we_req = we;
        d_re_req = we ? 1'($urandom) : 1'b1;
        @(negedge clk);
        check("d_idle", idle, 1);
        check("d_idle_mem", {m_re, m_we}, 0);
        next_cycle();
        d_we_req = 1'b0;
        d_re_req = 1'b0;
        if (!hit && dirty)
            mem_phase(0, t * (1 << IW) + (a / LWD) % (1 << IW), dw, rl);
        if (!hit) begin
            mem_phase(1, a / LWD, df, ml);
            d_rd_line = ml;
        end
        @(negedge clk);
        check("d_rdy", d_rdy, 1);
        check("d_we_fin", d_we, we);
        check("d_dirty_wr", d_dirty_wr, we);
        check("d_re_fin", d_re, !we);
        check("d_fin_mem", {m_re, m_we}, 0);
        if (we) begin
            sh = (a % LWD) * WW;
            mask = LW'({WW{1'b1}}) << sh;
            exp_l = (d_rd_line & ~mask) | (LW'(wd) << sh);
            check("d_merge", d_wr_line, exp_l);
        end
        next_cycle();
    endtask

    task automatic i_txn(input bit hit, input int df);
        logic [AW-1:0] a;
        logic [LW-1:0] ml;
        a = AW'($urandom);
        ml = rnd_line();
        i_addr = a; i_hit = hit; m_rd_line = ml;
        i_req = 1'b1; d_re_req = 1'b0; d_we_req = 1'b0; m_rdy = 1'b0;
        @(negedge clk);
        check("i_idle", idle, 1);
        next_cycle();
        i_req = 1'b0;
        if (!hit) mem_phase(2, a / LWD, df, ml);
        @(negedge clk);
        check("i_rdy", i_rdy, 1);
        check("i_we_fin", i_we, 0);
        check("i_fin_d", d_rdy, 0);
        next_cycle();
    endtask

    initial begin
        int waited;
        bit saw_irdy;
        logic [255:0] wl;
        i_req = 0; i_hit = 0; i_addr = '0;
        d_re_req = 0; d_we_req = 0; d_hit = 0; d_dirty = 0;
        d_addr = '0; d_wdata = '0; d_tag = '0; d_rd_line = '0;
        m_rd_line = '0; m_rdy = 0;
        w_we_req = 0; w_hit = 0; w_addr = '0; w_wdata = '0; w_rd_line = '0;

        #2;
        check("rst_strobes",
              {idle, d_re, d_we, d_rdy, i_we, i_rdy, m_re, m_we, m_err}, 0);
        check("rst_sticky", err_sticky, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("post_rst_idle", {idle, d_re}, 2'b11);
        next_cycle();

        // Read hit at 0x1235, then dirty write miss at 0x1236 with tag 0xAB.
        d_txn(1'b0, 1'b1, 1'b0, 16'h1235, 8'h00, 0, 0);
        d_txn(1'b1, 1'b0, 1'b1, 16'h1236, 8'hAB, 3, 3);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 3)
                i_txn(1'($urandom), $urandom_range(0, 4));
            else
                d_txn(1'($urandom), 1'($urandom), 1'($urandom),
                      AW'($urandom), TW'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Both sides requesting hits nonstop: every fourth grant goes to I.
        i_req = 1; d_re_req = 1; i_hit = 1; d_hit = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("arb_idle", idle, 1);
            next_cycle();
            @(negedge clk);
            check("arb_i", i_rdy, (k % 4) == 3);
            check("arb_d", d_rdy, (k % 4) != 3);
            next_cycle();
        end
        i_req = 0; d_re_req = 0;

        // Instruction fill whose memory never answers.
        i_req = 1; i_hit = 0; m_rdy = 0;
        @(negedge clk);
        check("to_idle", idle, 1);
        next_cycle();
        i_req = 0;
        waited = 0;
        saw_irdy = 0;
        while (waited < 2 * MT) begin
            @(negedge clk);
            if (i_rdy || i_we) saw_irdy = 1;
            if (!m_re) break;
            waited++;
            next_cycle();
        end
        check("to_cycles", waited, MT);
        check("to_merr", m_err, 1);
        check("to_sticky", err_sticky, 1);
        check("to_irdy", saw_irdy, 0);
        next_cycle();
        @(negedge clk);
        check("to_back", {idle, m_err, err_sticky}, 3'b101);
        next_cycle();

        // Reset in the middle of a clean D fill.
        d_re_req = 1; d_hit = 0; d_dirty = 0; d_addr = 16'h0420;
        @(negedge clk);
        next_cycle();
        d_re_req = 0;
        @(negedge clk);
        check("mr_fill", m_re, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_drop",
              {idle, d_re, m_re, m_we, d_we, d_rdy, i_we, m_addr}, 0);
        next_cycle();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("mr_idle", idle, 1);
        check("mr_sticky", err_sticky, 0);
        m_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check("mr_quiet", {d_we, i_we, m_we, m_re, d_rdy}, 0);
        end
        m_rdy = 0;
        next_cycle();

        // Wide-line instance: write hit to word 7.
        wl = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
        w_rd_line = wl;
        w_wdata = $urandom;
        w_addr = {13'($urandom), 3'd7};
        w_hit = 1; w_we_req = 1;
        @(negedge clk);
        check("w_idle", w_idle, 1);
        next_cycle();
        w_we_req = 0;
        @(negedge clk);
        check("w_rdy", {w_d_rdy, w_d_we, w_d_dirty_wr}, 3'b111);
        check("w_hi", w_d_wr_line[255:224], w_wdata);
        check("w_lo", w_d_wr_line[223:0], wl[223:0]);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
